// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: imem req/gnt/rvalid port,
// redirect from EX and head-word handoff to the compressed FSM.
interface if_fetch_queue_if;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [63:0] i_redirect_target;
  logic        i_incr_pc;
  logic        i_ex_ready;
  logic [31:0] o_instr;
  logic [63:0] o_if_pc;
  logic        o_valid;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    input  i_redirect,
    input  i_redirect_target,
    input  i_incr_pc,
    input  i_ex_ready,
    output o_instr,
    output o_if_pc,
    output o_valid
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata,
    output i_redirect,
    output i_redirect_target,
    output i_incr_pc,
    output i_ex_ready,
    input  o_instr,
    input  o_if_pc,
    input  o_valid
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: word fetches, small FIFO,
// flush and stale-response discard on redirect.
module if_fetch_queue #(
  parameter logic [63:0] BOOT_ADDR = 64'h0,
  parameter int          DEPTH     = 2
) (
  input logic           clk,
  input logic           rst,
  if_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = CW + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] BOOT_PC = {BOOT_ADDR[63:2], 2'b00};
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
  localparam logic [DW-1:0] DMAX = '1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   head_pc_q, head_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic          req;
  logic          fire;
  logic          push;
  logic          pop;
  logic          drop;
  logic [CW:0]   inflight;
  logic [DW:0]   pending;
  logic [63:0]   tgt_pc;

  // Handshake decode: request gating, push/pop/drop qualification.
  always_comb begin
    inflight = {1'b0, count_q} + {1'b0, outst_q};
    tgt_pc   = {bus.i_redirect_target[63:2], 2'b00};
    req      = !rst && !bus.i_redirect && (inflight < LIMIT);
    fire     = req && bus.i_imem_gnt;
    drop     = bus.i_imem_rvalid && (discard_q != '0);
    push     = bus.i_imem_rvalid && (discard_q == '0)
               && !bus.i_redirect;
    pop      = (count_q != '0) && bus.i_incr_pc
               && bus.i_ex_ready && !bus.i_redirect;
  end

  // Next-state: redirect flushes everything, else fire/push/pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;
    pending    = '0;
    if (bus.i_redirect) begin
      fetch_pc_d = tgt_pc;
      head_pc_d  = tgt_pc;
      count_d    = '0;
      outst_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything already granted comes back stale; a
      // response landing now is one of them and is dropped.
      pending = {1'b0, discard_q} + (DW + 1)'(outst_q);
      if (bus.i_imem_rvalid && pending != '0)
        pending = pending - 1'b1;
      // Saturate for pathological back-to-back redirects.
      if (pending > {1'b0, DMAX})
        discard_d = DMAX;
      else
        discard_d = pending[DW-1:0];
    end else begin
      if (fire)
        fetch_pc_d = fetch_pc_q + 64'd4;
      if (drop)
        discard_d = discard_q - 1'b1;
      if (push) begin
        mem_d[wr_ptr_q] = bus.i_imem_rdata;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        head_pc_d = head_pc_q + 64'd4;
      end
      unique case (1'b1)
        push && !pop: count_d = count_q + 1'b1;
        !push && pop: count_d = count_q - 1'b1;
        default:      count_d = count_q;
      endcase
      unique case (1'b1)
        fire && !push: outst_d = outst_q + 1'b1;
        !fire && push: outst_d = outst_q - 1'b1;
        default:       outst_d = outst_q;
      endcase
    end
  end

  // Control/bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= BOOT_PC;
      head_pc_q  <= BOOT_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are masked by count, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc_q;
  assign bus.o_valid     = (count_q != '0);
  assign bus.o_instr     = (count_q != '0) ? mem_q[rd_ptr_q] : NOP;
  assign bus.o_if_pc     = head_pc_q;

endmodule
